button_conditioner: RTL and testbench

//  Parametrised successor to the per-button debounce array. Conditions N_CH raw push-button

---
 rtl/button_conditioner.sv | 77 +++++++
 tb/tb_button_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises raw button pins, debounces them on a shared 1 ms tick and
// derives per-channel press, release, long-press and auto-repeat strobes.
module button_conditioner #(
  parameter int N_CH        = 5,
  parameter int CLK_HZ      = 25000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] buttons,
  input  logic [N_CH-1:0] rpt_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] rpt,
  output logic            tick_ms
);
  localparam int PER = CLK_HZ / 1000;
  localparam int PW = $clog2(PER);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [PW-1:0] PC_MAX = PW'(PER - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_MS - 1);
  localparam logic [15:0] HOLD_MAX = 16'(LONG_MS);
  localparam logic [15:0] HOLD_LAST = 16'(LONG_MS - 1);
  localparam logic [15:0] RP_LAST = 16'(REPEAT_MS - 1);
  localparam logic [N_CH-1:0] IDLE = {N_CH{ACTIVE_LOW}};
  logic [PW-1:0] pc;
  logic [N_CH-1:0] sync1, sync2, s;
  assign s = sync2 ^ IDLE;
  assign tick_ms = pc == PC_MAX;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else pc <= tick_ms ? '0 : pc + 1'b1;
  // Flops start at the released pin value so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
    end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DW-1:0] db_cnt;
    logic [15:0] hold_cnt, rp_cnt;
    logic flip, drop, at_long, rp_wrap;
    assign flip = tick_ms && s[i] != level[i] && db_cnt == DB_LAST;
    assign drop = flip && level[i];
    assign at_long = hold_cnt == HOLD_MAX;
    assign rp_wrap = tick_ms && at_long && rp_cnt == RP_LAST;
    // A release accepted on the same tick suppresses any repeat due on that tick.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        level[i] <= 1'b0;
        press[i] <= 1'b0;
        rel[i] <= 1'b0;
        long_press[i] <= 1'b0;
        rpt[i] <= 1'b0;
        db_cnt <= '0;
        hold_cnt <= '0;
        rp_cnt <= '0;
      end else begin
        level[i] <= level[i] ^ flip;
        press[i] <= flip && !level[i];
        rel[i] <= drop;
        db_cnt <= (s[i] == level[i] || flip) ? '0 : db_cnt + DW'(tick_ms);
        hold_cnt <= (!level[i] || press[i]) ? '0 : hold_cnt + 16'(tick_ms && !at_long);
        long_press[i] <= level[i] && !press[i] && tick_ms && hold_cnt == HOLD_LAST;
        rp_cnt <= (long_press[i] || !level[i] || drop || rp_wrap) ? '0 : rp_cnt + 16'(tick_ms && at_long);
        rpt[i] <= level[i] && !long_press[i] && !drop && rp_wrap && rpt_en[i];
      end
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed stimulus on an active-high and an active-low
// instance, checked every cycle against a tick-counting reference model.
module tb_button_conditioner;
  localparam int N = 5, P = 10, DB = 3, LONG = 8, REP = 2;
  logic clk = 0, rst_a = 0, rst_b = 0;
  logic [N-1:0] btn_a = '1, btn_b = '1, rpt_en = '0;
  logic [N-1:0] lvl_a, pr_a, rl_a, lp_a, rp_a, lvl_b, pr_b, rl_b, lp_b, rp_b;
  logic tk_a, tk_b;
  int checks = 0, failures = 0, cyc = 0;
  int cnt_pr [2][N], cnt_rl [2][N], cnt_lp [2][N], cnt_rp [2][N];
  logic [N-1:0] first_pr;
  int m_cyc [2], m_dif [2][N], m_held [2][N];
  bit [N-1:0] m_s1 [2], m_s2 [2], m_lvl [2], m_pr [2], m_rl [2], m_lp [2], m_rp [2];

  button_conditioner #(.N_CH(N), .CLK_HZ(10000), .DEBOUNCE_MS(DB), .LONG_MS(LONG),
    .REPEAT_MS(REP), .ACTIVE_LOW(1'b0)) dut_a (.clk(clk), .rst_n(rst_a), .buttons(btn_a),
    .rpt_en(rpt_en), .level(lvl_a), .press(pr_a), .rel(rl_a), .long_press(lp_a), .rpt(rp_a),
    .tick_ms(tk_a));
  button_conditioner #(.N_CH(N), .CLK_HZ(10000), .DEBOUNCE_MS(DB), .LONG_MS(LONG),
    .REPEAT_MS(REP), .ACTIVE_LOW(1'b1)) dut_b (.clk(clk), .rst_n(rst_b), .buttons(btn_b),
    .rpt_en(rpt_en), .level(lvl_b), .press(pr_b), .rel(rl_b), .long_press(lp_b), .rpt(rp_b),
    .tick_ms(tk_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input int d, input bit al);
    m_cyc[d] = 0;
    m_s1[d] = {N{al}};
    m_s2[d] = {N{al}};
    m_lvl[d] = '0; m_pr[d] = '0; m_rl[d] = '0; m_lp[d] = '0; m_rp[d] = '0;
    for (int c = 0; c < N; c++) begin
      m_dif[d][c] = 0;
      m_held[d][c] = 0;
    end
  endtask

  // Level flips after DB ticks of continuous disagreement; held ticks count up while pressed,
  // long press at LONG ticks, repeats at LONG + k*REP ticks.
  task automatic model_step(input int d, input bit al, input logic [N-1:0] pins);
    bit tick;
    bit [N-1:0] s, old, npr, nrl, nlp, nrp;
    tick = (m_cyc[d] % P) == P - 1;
    s = m_s2[d] ^ {N{al}};
    old = m_lvl[d];
    npr = '0; nrl = '0; nlp = '0; nrp = '0;
    for (int c = 0; c < N; c++) begin
      bit flip;
      flip = 0;
      if (s[c] == old[c]) m_dif[d][c] = 0;
      else if (tick) begin
        m_dif[d][c]++;
        if (m_dif[d][c] == DB) begin
          flip = 1;
          m_dif[d][c] = 0;
        end
      end
      if (!old[c]) m_held[d][c] = 0;
      else if (tick) begin
        if (m_held[d][c] == LONG - 1) nlp[c] = 1;
        if (m_held[d][c] >= LONG && (m_held[d][c] + 1 - LONG) % REP == 0 && !flip && rpt_en[c])
          nrp[c] = 1;
        m_held[d][c]++;
      end
      if (flip) begin
        if (old[c]) nrl[c] = 1; else npr[c] = 1;
        m_lvl[d][c] = ~old[c];
      end
    end
    m_pr[d] = npr; m_rl[d] = nrl; m_lp[d] = nlp; m_rp[d] = nrp;
    m_s2[d] = m_s1[d];
    m_s1[d] = pins;
    m_cyc[d]++;
  endtask

  always @(posedge clk or negedge rst_a or negedge rst_b) begin
    if (!rst_a) model_reset(0, 1'b0); else if (clk) model_step(0, 1'b0, btn_a);
    if (!rst_b) model_reset(1, 1'b1); else if (clk) model_step(1, 1'b1, btn_b);
  end

  task automatic clr();
    first_pr = '0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        cnt_pr[d][c] = 0; cnt_rl[d][c] = 0; cnt_lp[d][c] = 0; cnt_rp[d][c] = 0;
      end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    chk("a.level", 32'(lvl_a), 32'(m_lvl[0]));
    chk("a.press", 32'(pr_a), 32'(m_pr[0]));
    chk("a.release", 32'(rl_a), 32'(m_rl[0]));
    chk("a.long", 32'(lp_a), 32'(m_lp[0]));
    chk("a.repeat", 32'(rp_a), 32'(m_rp[0]));
    chk("a.tick", 32'(tk_a), 32'(rst_a && (m_cyc[0] % P) == P - 1));
    chk("b.level", 32'(lvl_b), 32'(m_lvl[1]));
    chk("b.press", 32'(pr_b), 32'(m_pr[1]));
    chk("b.release", 32'(rl_b), 32'(m_rl[1]));
    chk("b.long", 32'(lp_b), 32'(m_lp[1]));
    chk("b.repeat", 32'(rp_b), 32'(m_rp[1]));
    chk("b.tick", 32'(tk_b), 32'(rst_b && (m_cyc[1] % P) == P - 1));
    if (pr_a != '0 && first_pr == '0) first_pr = pr_a;
    for (int c = 0; c < N; c++) begin
      cnt_pr[0][c] += int'(pr_a[c]); cnt_rl[0][c] += int'(rl_a[c]);
      cnt_lp[0][c] += int'(lp_a[c]); cnt_rp[0][c] += int'(rp_a[c]);
      cnt_pr[1][c] += int'(pr_b[c]); cnt_rl[1][c] += int'(rl_b[c]);
      cnt_lp[1][c] += int'(lp_b[c]); cnt_rp[1][c] += int'(rp_b[c]);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int tp, tl, tr;
    clr();
    // 1: reset with all buttons pressed, then simultaneous presses
    run(4);
    chk("t1.rst_outs", 32'({lvl_a, pr_a, rl_a, lp_a, rp_a, tk_a}), 32'd0);
    rst_a = 1; rst_b = 1;
    clr();
    run(42);
    chk("t1.level", 32'(lvl_a), 32'h1F);
    chk("t1.first_press", 32'(first_pr), 32'h1F);
    chk("t1.press0", 32'(cnt_pr[0][0]), 1);
    chk("t1.press4", 32'(cnt_pr[0][4]), 1);
    chk("t1.no_rel", 32'(cnt_rl[0][2]), 0);
    btn_a = '0;
    run(60);
    // 2: bounce on channel 0
    clr();
    for (int i = 0; i < 14; i++) begin
      btn_a[0] = ~btn_a[0];
      run(7);
    end
    chk("t2.bounce_press", 32'(cnt_pr[0][0]), 0);
    chk("t2.bounce_level", 32'(lvl_a[0]), 0);
    btn_a[0] = 1;
    run(42);
    chk("t2.level", 32'(lvl_a[0]), 1);
    chk("t2.press_cnt", 32'(cnt_pr[0][0]), 1);
    btn_a[0] = 0;
    run(60);
    // 3: long press then repeats every 2 ticks
    clr();
    rpt_en[1] = 1;
    btn_a[1] = 1;
    for (int k = 0; k < 60 && !pr_a[1]; k++) step();
    chk("t3.press_seen", 32'(pr_a[1]), 1);
    tp = cyc;
    for (int k = 0; k < 120 && !lp_a[1]; k++) step();
    chk("t3.long_delay", 32'(cyc - tp), 80);
    tl = cyc;
    for (int k = 0; k < 40 && !rp_a[1]; k++) step();
    chk("t3.rep1_delay", 32'(cyc - tl), 20);
    tr = cyc;
    step();
    for (int k = 0; k < 40 && !rp_a[1]; k++) step();
    chk("t3.rep2_delay", 32'(cyc - tr), 20);
    btn_a[1] = 0;
    for (int k = 0; k < 60 && !rl_a[1]; k++) step();
    chk("t3.rel_seen", 32'(rl_a[1]), 1);
    chk("t3.rel_no_rep", 32'(rp_a[1]), 0);
    clr();
    run(60);
    chk("t3.rep_after", 32'(cnt_rp[0][1]), 0);
    chk("t3.rel_after", 32'(cnt_rl[0][1]), 0);
    // 4: same hold with repeat disabled
    clr();
    rpt_en[1] = 0;
    btn_a[1] = 1;
    run(160);
    chk("t4.long_cnt", 32'(cnt_lp[0][1]), 1);
    chk("t4.rep_cnt", 32'(cnt_rp[0][1]), 0);
    btn_a[1] = 0;
    run(60);
    // 5: short press
    clr();
    btn_a[2] = 1;
    run(50);
    btn_a[2] = 0;
    run(60);
    chk("t5.press", 32'(cnt_pr[0][2]), 1);
    chk("t5.release", 32'(cnt_rl[0][2]), 1);
    chk("t5.no_long", 32'(cnt_lp[0][2]), 0);
    // 6: active-low pin, reset mid-hold
    clr();
    btn_b[3] = 0;
    run(42);
    chk("t6.level", 32'(lvl_b[3]), 1);
    chk("t6.press", 32'(cnt_pr[1][3]), 1);
    run(10);
    rst_b = 0;
    #1;
    chk("t6.rst_level", 32'(lvl_b), 0);
    chk("t6.rst_strobes", 32'({pr_b, rl_b, lp_b, rp_b, tk_b}), 0);
    run(3);
    rst_b = 1;
    clr();
    run(42);
    chk("t6.repress_level", 32'(lvl_b[3]), 1);
    chk("t6.repress", 32'(cnt_pr[1][3]), 1);
    chk("t6.no_release", 32'(cnt_rl[1][3]), 0);
    btn_b[3] = 1;
    run(60);
    // random soak on both instances
    for (int k = 0; k < 4000; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 29) == 0) btn_a[c] = ~btn_a[c];
        if ($urandom_range(0, 29) == 0) btn_b[c] = ~btn_b[c];
        if ($urandom_range(0, 49) == 0) rpt_en[c] = ~rpt_en[c];
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
